// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller.
// Arbitrates the single data-memory port between the load/store path and the
// stack unit (CALL/RET push/pop), owns the stack pointer and sequences each
// access through IDLE -> ISSUE -> (WAIT) -> DONE against a memory with a
// registered read port.
module dmem_access_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int SP_BASE   = 255,
  parameter int SP_LIMIT  = 128
) (
  input  logic              clock,
  input  logic              reset,
  // load/store requester
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  // stack requester
  input  logic              stk_req,
  input  logic              stk_pop,
  input  logic [DATA_W-1:0] stk_wdata,
  output logic              stk_ack,
  output logic              stk_err,
  output logic [DATA_W-1:0] stk_rdata,
  output logic [DATA_W-1:0] sp,
  output logic              busy,
  // data memory port
  output logic              mem_en,
  output logic              mem_enr,
  output logic              mem_enw,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] DEPTH_V = DATA_W'(MEM_DEPTH);
  localparam logic [DATA_W-1:0] BASE_V  = DATA_W'(SP_BASE);
  localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(SP_LIMIT);
  localparam logic [DATA_W-1:0] ONE_V   = DATA_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {GNT_LS, GNT_STK} grant_t;

  state_t state;
  grant_t last_grant;
  grant_t cur_grant;
  logic   cur_read;
  logic   cur_pop;
  logic   cur_err;
  logic   en_q;
  logic   enr_q;
  logic   enw_q;

  logic              pick_ls;
  logic              any_req;
  logic              req_err;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Round-robin grant decision and the access it would perform this cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    pick_ls   = ls_req && (!stk_req || (last_grant == GNT_STK));
    any_req   = ls_req || stk_req;
    req_err   = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    if (pick_ls) begin
      req_err   = (ls_addr >= DEPTH_V);
      req_write = ls_we;
      req_addr  = ls_addr;
      req_wdata = ls_we ? ls_wdata : '0;
    end else if (stk_pop) begin
      // pop reads the slot just above the next-free pointer
      req_err   = (sp == BASE_V);
      req_write = 1'b0;
      req_addr  = sp + ONE_V;
    end else begin
      req_err   = (sp < LIMIT_V);
      req_write = 1'b1;
      req_addr  = sp;
      req_wdata = stk_wdata;
    end
  end

  // Memory strobes are forced low while reset is high so a reset cycle never writes.
  always_comb begin
    mem_en  = en_q  && !reset;
    mem_enr = enr_q && !reset;
    mem_enw = enw_q && !reset;
    busy    = (state != S_IDLE);
  end

  // Access sequencer: grant, issue, wait for read data, acknowledge and commit SP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= GNT_STK;
      cur_grant  <= GNT_LS;
      cur_read   <= 1'b0;
      cur_pop    <= 1'b0;
      cur_err    <= 1'b0;
      sp         <= BASE_V;
      ls_ack     <= 1'b0;
      ls_err     <= 1'b0;
      ls_rdata   <= '0;
      stk_ack    <= 1'b0;
      stk_err    <= 1'b0;
      stk_rdata  <= '0;
      en_q       <= 1'b0;
      enr_q      <= 1'b0;
      enw_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; the defaults below are
      // overridden by later assignments in the same cycle, giving one-cycle pulses.
      ls_ack    <= 1'b0;
      ls_err    <= 1'b0;
      stk_ack   <= 1'b0;
      stk_err   <= 1'b0;
      en_q      <= 1'b0;
      enr_q     <= 1'b0;
      enw_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            cur_grant <= pick_ls ? GNT_LS : GNT_STK;
            cur_read  <= !req_write;
            cur_pop   <= !pick_ls && stk_pop;
            cur_err   <= req_err;
            if (req_err) begin
              // rejected at grant: acknowledge with error, memory untouched
              ls_ack  <= pick_ls;
              ls_err  <= pick_ls;
              stk_ack <= !pick_ls;
              stk_err <= !pick_ls;
              state   <= S_DONE;
            end else begin
              en_q      <= 1'b1;
              enr_q     <= !req_write;
              enw_q     <= req_write;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cur_read) begin
            state <= S_WAIT;
          end else begin
            ls_ack  <= (cur_grant == GNT_LS);
            stk_ack <= (cur_grant == GNT_STK);
            state   <= S_DONE;
          end
        end
        S_WAIT: begin
          if (cur_grant == GNT_LS) ls_rdata  <= mem_rdata;
          else                     stk_rdata <= mem_rdata;
          ls_ack  <= (cur_grant == GNT_LS);
          stk_ack <= (cur_grant == GNT_STK);
          state   <= S_DONE;
        end
        S_DONE: begin
          if (!cur_err && (cur_grant == GNT_STK)) begin
            sp <= cur_pop ? (sp + ONE_V) : (sp - ONE_V);
          end
          last_grant <= cur_grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
